// File: rtl/multi_cycle_ctrl_pkg.sv
// multi_cycle_ctrl_pkg: states, opcodes, datapath mux encodings and per-state control decode
package multi_cycle_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, R_WB, ADDI_WB, BRANCH, JUMP, FAULT
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_4      = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  // Moore part of the control word; memReady/opCode-dependent enables are added in the top
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ior_d;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       retire;
    logic       fault;
  } ctrl_t;

  function automatic logic legal_op(logic [5:0] op);
    return op inside {OP_R, OP_LW, OP_SW, OP_ADDI, OP_BEQ, OP_J};
  endfunction

  function automatic ctrl_t state_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_4;
      end
      DECODE: c.alu_src_b = SRCB_IMM_SH;
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
      end
      MEM_RD: begin
        c.mem_read = 1'b1;
        c.ior_d    = 1'b1;
      end
      MEM_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.retire     = 1'b1;
      end
      MEM_WR: begin
        c.mem_write = 1'b1;
        c.ior_d     = 1'b1;
      end
      EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = ALU_FUNCT;
      end
      R_WB: begin
        c.reg_write = 1'b1;
        c.reg_dst   = 1'b1;
        c.retire    = 1'b1;
      end
      ADDI_WB: begin
        c.reg_write = 1'b1;
        c.retire    = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = ALU_SUB;
        c.pc_write_cond = 1'b1;
        c.pc_source     = PC_ALUOUT;
        c.retire        = 1'b1;
      end
      JUMP: begin
        c.pc_write  = 1'b1;
        c.pc_source = PC_JUMP;
        c.retire    = 1'b1;
      end
      FAULT: c.fault = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// multi_cycle_ctrl_if: controller <-> datapath control bus
interface multi_cycle_ctrl_if;
  logic [5:0] opCode;
  logic       memReady;
  logic       pcWrite;
  logic       pcWriteCond;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic [1:0] aluOp;
  logic [1:0] pcSource;
  logic       retire;
  logic       illegal;
  logic       fault;

  modport master (
    input  opCode, memReady,
    output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst, memToReg,
           regWrite, aluSrcA, aluSrcB, aluOp, pcSource, retire, illegal, fault
  );

  modport slave (
    output opCode, memReady,
    input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst, memToReg,
           regWrite, aluSrcA, aluSrcB, aluOp, pcSource, retire, illegal, fault
  );
endinterface

// File: rtl/multi_cycle_ctrl_mem_wait_timer.sv
// mem_wait_timer: counts unanswered memory wait cycles and flags the last allowed one
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  output logic expired
);
  logic [7:0] count;
  // any cycle that is not an unanswered wait restarts the count, so each access starts at 0
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= inc ? count + 8'd1 : '0;
  assign expired = inc && count == 8'(MEM_TIMEOUT - 1);
endmodule

// File: rtl/multi_cycle_ctrl.sv
// multi_cycle_ctrl: multi-cycle MIPS sequencing FSM driving datapath enables and mux selects
module multi_cycle_ctrl
  import multi_cycle_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input logic clock,
  input logic reset,
  multi_cycle_ctrl_if.master bus
);
  state_t state, nxt;
  ctrl_t q;
  logic waiting, expired, bad;
  assign waiting = state inside {FETCH, MEM_RD, MEM_WR};
  assign bad = state == DECODE && !legal_op(bus.opCode);
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clock(clock),
    .reset(reset),
    .inc(waiting && !bus.memReady),
    .expired(expired)
  );
  // next state; memReady beats a timeout that expires in the same cycle
  always_comb begin
    nxt = state;
    case (state)
      FETCH:    nxt = bus.memReady ? DECODE : expired ? FAULT : FETCH;
      DECODE:   nxt = bus.opCode == OP_R ? EXEC
                    : (bus.opCode inside {OP_LW, OP_SW, OP_ADDI}) ? MEM_ADDR
                    : bus.opCode == OP_BEQ ? BRANCH
                    : bus.opCode == OP_J ? JUMP : FETCH;
      MEM_ADDR: nxt = bus.opCode == OP_LW ? MEM_RD : bus.opCode == OP_SW ? MEM_WR : ADDI_WB;
      MEM_RD:   nxt = bus.memReady ? MEM_WB : expired ? FAULT : MEM_RD;
      MEM_WR:   nxt = bus.memReady ? FETCH : expired ? FAULT : MEM_WR;
      EXEC:     nxt = R_WB;
      FAULT:    nxt = FAULT;
      default:  nxt = FETCH;
    endcase
  end
  // state register with the Moore control word registered from the next state
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= FETCH;
      q     <= state_ctrl(FETCH);
    end else begin
      state <= nxt;
      q     <= state_ctrl(nxt);
    end
  assign bus.pcWrite     = !reset && (q.pc_write || (state == FETCH && bus.memReady));
  assign bus.irWrite     = !reset && state == FETCH && bus.memReady;
  assign bus.pcWriteCond = !reset && q.pc_write_cond;
  assign bus.regWrite    = !reset && q.reg_write;
  assign bus.memWrite    = !reset && q.mem_write;
  assign bus.retire      = !reset && (q.retire || bad || (state == MEM_WR && bus.memReady));
  assign bus.illegal     = !reset && bad;
  assign bus.fault       = !reset && q.fault;
  assign bus.iorD        = q.ior_d;
  assign bus.memRead     = q.mem_read;
  assign bus.regDst      = q.reg_dst;
  assign bus.memToReg    = q.mem_to_reg;
  assign bus.aluSrcA     = q.alu_src_a;
  assign bus.aluSrcB     = q.alu_src_b;
  assign bus.aluOp       = q.alu_op;
  assign bus.pcSource    = q.pc_source;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// tb_multi_cycle_ctrl: random instruction stream checked against a per-instruction expected-trace model
module tb_multi_cycle_ctrl;
  localparam int TMO = 4;
  localparam logic [5:0] R = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] ADDI = 6'b001000, BEQ = 6'b000100, J = 6'b000010;

  typedef struct packed {
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic       retire, illegal, fault;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  multi_cycle_ctrl_if b();
  multi_cycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (.clock(clock), .reset(reset), .bus(b.master));

  always #5 clock = ~clock;

  exp_t act, expv, fetch_v;
  string tag;
  logic chk = 1'b0;
  logic abort_wr = 1'b0;
  int pass = 0, total = 0, ncyc = 0;

  assign act = {b.pcWrite, b.pcWriteCond, b.iorD, b.memRead, b.memWrite, b.irWrite, b.regDst, b.memToReg,
                b.regWrite, b.aluSrcA, b.aluSrcB, b.aluOp, b.pcSource, b.retire, b.illegal, b.fault};

  function automatic void check(string t, exp_t e);
    total++;
    if (act === e) pass++;
    else $display("FAIL %s @%0t: got %b want %b", t, $time, act, e);
  endfunction

  // the single per-cycle comparison against the model's expected control word
  always @(negedge clock) if (chk) check(tag, expv);

  function automatic logic is_legal(logic [5:0] op);
    return op == R || op == LW || op == SW || op == ADDI || op == BEQ || op == J;
  endfunction

  task automatic step(string t, logic rdy, exp_t e);
    tag = t;
    b.memReady = rdy;
    expv = e;
    chk = 1'b1;
    ncyc++;
    @(posedge clock);
    #1;
  endtask

  // reset is raised between edges: strobes must drop at once and writes stay gated while it is high
  task automatic do_reset();
    chk = 1'b0;
    b.memReady = 1'b1;
    reset = 1'b1;
    #1 check("reset_async", fetch_v);
    tag = "reset_held";
    expv = fetch_v;
    chk = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    chk = 1'b0;
  endtask

  task automatic fault_phase();
    exp_t f;
    f = '0;
    f.fault = 1'b1;
    for (int i = 0; i < 3; i++) step("fault", 1'($urandom), f);
    do_reset();
  endtask

  // a memory access answered after n unanswered cycles, or a timeout after TMO of them
  task automatic access(string t, exp_t w, exp_t d, int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < TMO; i++) begin
      if (i == n) begin
        step(t, 1'b1, d);
        ok = 1'b1;
        return;
      end
      step(t, 1'b0, w);
    end
  endtask

  task automatic run_instr(logic [5:0] op, int fw, int mw);
    exp_t e, d;
    logic ok;
    d = fetch_v;
    d.irWrite = 1'b1;
    d.pcWrite = 1'b1;
    b.opCode = 6'($urandom);
    access("fetch", fetch_v, d, fw, ok);
    if (!ok) begin
      fault_phase();
      return;
    end
    b.opCode = op;
    e = '0;
    e.aluSrcB = 2'b11;
    if (!is_legal(op)) begin
      e.illegal = 1'b1;
      e.retire = 1'b1;
      step("decode_illegal", 1'($urandom), e);
      return;
    end
    step("decode", 1'($urandom), e);
    e = '0;
    if (op == R) begin
      e.aluSrcA = 1'b1;
      e.aluOp = 2'b10;
      step("exec", 1'($urandom), e);
      e = '0;
      e.regWrite = 1'b1;
      e.regDst = 1'b1;
      e.retire = 1'b1;
      step("r_wb", 1'($urandom), e);
    end else if (op == BEQ) begin
      e.aluSrcA = 1'b1;
      e.aluOp = 2'b01;
      e.pcWriteCond = 1'b1;
      e.pcSource = 2'b01;
      e.retire = 1'b1;
      step("branch", 1'($urandom), e);
    end else if (op == J) begin
      e.pcWrite = 1'b1;
      e.pcSource = 2'b10;
      e.retire = 1'b1;
      step("jump", 1'($urandom), e);
    end else begin
      e.aluSrcA = 1'b1;
      e.aluSrcB = 2'b10;
      step("mem_addr", 1'($urandom), e);
      e = '0;
      if (op == ADDI) begin
        e.regWrite = 1'b1;
        e.retire = 1'b1;
        step("addi_wb", 1'($urandom), e);
      end else if (op == LW) begin
        e.memRead = 1'b1;
        e.iorD = 1'b1;
        access("mem_rd", e, e, mw, ok);
        if (!ok) begin
          fault_phase();
          return;
        end
        e = '0;
        e.regWrite = 1'b1;
        e.memToReg = 1'b1;
        e.retire = 1'b1;
        step("mem_wb", 1'($urandom), e);
      end else begin
        e.memWrite = 1'b1;
        e.iorD = 1'b1;
        if (abort_wr) begin
          step("mem_wr", 1'b0, e);
          chk = 1'b0;
          b.memReady = 1'b0;
          #1 check("mem_wr_held", e);
          do_reset();
          return;
        end
        d = e;
        d.retire = 1'b1;
        access("mem_wr", e, d, mw, ok);
        if (!ok) fault_phase();
      end
    end
  endtask

  task automatic latency(string t, logic [5:0] op, int fw, int mw, int want);
    ncyc = 0;
    run_instr(op, fw, mw);
    total++;
    if (ncyc == want) pass++;
    else $display("FAIL latency_%s: got %0d cycles want %0d", t, ncyc, want);
  endtask

  logic [5:0] ops[6] = '{R, LW, SW, ADDI, BEQ, J};

  initial begin
    fetch_v = '0;
    fetch_v.memRead = 1'b1;
    fetch_v.aluSrcB = 2'b01;
    b.opCode = '0;
    b.memReady = 1'b0;
    @(posedge clock);
    #1 do_reset();
    latency("r", R, 0, 0, 4);
    latency("lw", LW, 0, 0, 5);
    latency("sw", SW, 0, 0, 4);
    latency("addi", ADDI, 0, 0, 4);
    latency("beq", BEQ, 0, 0, 3);
    latency("j", J, 0, 0, 3);
    latency("illegal", 6'b111111, 0, 0, 2);
    latency("lw_wait3", LW, 0, 3, 8);
    latency("fetch_ready_last", R, TMO - 1, 0, TMO + 3);
    latency("fetch_timeout", R, TMO, 0, TMO + 3);
    latency("sw_timeout", SW, 1, TMO, 4 + TMO + 3);
    abort_wr = 1'b1;
    latency("sw_abort", SW, 0, 0, 4);
    abort_wr = 1'b0;
    latency("after_abort", R, 0, 0, 4);
    for (int k = 0; k < 250; k++) begin
      logic [5:0] op;
      int fw, mw;
      if ($urandom_range(0, 7) == 0) begin
        op = 6'($urandom);
        while (is_legal(op)) op = 6'($urandom);
      end else op = ops[$urandom_range(0, 5)];
      fw = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, TMO + 1)) : 0;
      mw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TMO + 1)) : 0;
      run_instr(op, fw, mw);
    end
    chk = 1'b0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
